// File: rtl/button_irq_if.sv
// CPU-side interrupt bus for the game-pad front end: mask/ack in, request/status out.
interface button_irq_if;
    logic [7:0] mask;
    logic       irq_ack;
    logic       irq;
    logic [3:0] irq_id;
    logic [7:0] pending;
    logic [7:0] held;

    modport slave  (input mask, irq_ack, output irq, irq_id, pending, held);
    modport master (output mask, irq_ack, input irq, irq_id, pending, held);
endinterface

// File: rtl/button_irq_arbiter.sv
// Game-pad front end: per-button sync + debounce, press/auto-repeat event latching,
// and a round-robin arbiter serving one event at a time over an irq/ack handshake.
module button_irq_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic left,
    input  logic right,
    input  logic down,
    input  logic up,
    input  logic select,
    input  logic start,
    input  logic a,
    input  logic b,
    button_irq_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_RATE);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    logic [7:0] w_raw;
    logic [7:0] w_held;
    logic [7:0] w_rise;
    logic [7:0] w_rep_fire;
    logic [7:0] w_set;
    logic [7:0] w_pend_next;
    logic [7:0] r_pending;
    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_grant_idx;
    logic [2:0] r_last_grant;
    logic [2:0] w_cand;
    logic [2:0] w_pick;
    logic       w_found;
    logic       w_grant_load;
    logic       w_irq;

    assign w_raw = {b, a, start, select, up, down, right, left};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_btn
            logic            r_meta;
            logic            r_sync;
            logic            r_held;
            logic            r_held_d;
            logic [DB_W-1:0] r_db_cnt;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_meta   <= 1'b0;
                    r_sync   <= 1'b0;
                    r_held   <= 1'b0;
                    r_held_d <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_meta   <= w_raw[gi];
                    r_sync   <= r_meta;
                    r_held_d <= r_held;
                    if (r_sync == r_held) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_held   <= ~r_held;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign w_held[gi] = r_held;
            assign w_rise[gi] = r_held & ~r_held_d;

            // Only the movement buttons (left, right, down) auto-repeat.
            if (gi < 3) begin : g_rep
                logic [RP_W-1:0] r_rep_cnt;
                assign w_rep_fire[gi] = r_held && (r_rep_cnt == RP_LAST);
                always_ff @(posedge clk or negedge nreset) begin
                    if (!nreset)
                        r_rep_cnt <= '0;
                    else if (!r_held)
                        r_rep_cnt <= '0;
                    else if (w_rep_fire[gi])
                        r_rep_cnt <= RP_RELOAD;
                    else
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end else begin : g_norep
                assign w_rep_fire[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_set = (w_rise | w_rep_fire) & bus.mask;

    // A new event landing in the ack cycle wins over the ack clear.
    always_comb begin
        w_pend_next = r_pending;
        if (r_state == ST_GRANT && bus.irq_ack)
            w_pend_next[r_grant_idx] = 1'b0;
        w_pend_next = (w_pend_next | w_set) & bus.mask;
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_load = 1'b0;
        w_found      = 1'b0;
        w_pick       = r_last_grant;
        w_cand       = r_last_grant;
        for (int k = 1; k <= 8; k++) begin
            w_cand = r_last_grant + 3'(k);
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_GRANT;
                    w_grant_load = 1'b1;
                end
            end
            ST_GRANT: begin
                if (bus.irq_ack)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= 3'd7;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pend_next;
            if (w_grant_load) begin
                r_grant_idx  <= w_pick;
                r_last_grant <= w_pick;
            end
        end
    end

    assign w_irq       = (r_state == ST_GRANT);
    assign bus.irq     = w_irq;
    assign bus.irq_id  = w_irq ? ({1'b0, r_grant_idx} + 4'd1) : 4'd0;
    assign bus.pending = r_pending;
    assign bus.held    = w_held;
endmodule

// File: tb/tb_button_irq_arbiter.sv
// Scoreboard bench for button_irq_arbiter: expected grant ids are queued as buttons are
// driven and popped when irq rises.
module tb_button_irq_arbiter;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic left = 1'b0, right = 1'b0, down = 1'b0, up = 1'b0;
    logic select = 1'b0, start = 1'b0, a = 1'b0, b = 1'b0;

    button_irq_if bus();

    int n_checks = 0;
    int n_pass = 0;
    int exp_q[$];
    bit strict = 1'b1;
    bit ack_en = 1'b0;
    int ack_delay = 0;
    int grant_cnt = 0;

    always #5 clk = ~clk;

    button_irq_arbiter #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(16),
        .REPEAT_RATE(4)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .left(left),
        .right(right),
        .down(down),
        .up(up),
        .select(select),
        .start(start),
        .a(a),
        .b(b),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < budget) begin
            tick(1);
            t++;
        end
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Grant monitor: one line per granted event.
    initial begin : monitor
        logic prev;
        int   e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.irq && !prev) begin
                grant_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("grant irq_id=%0d expected=%0d t=%0t", bus.irq_id, e, $time);
                    check_eq("grant_id", int'(bus.irq_id), e);
                end else if (strict) begin
                    $display("grant irq_id=%0d expected=none t=%0t", bus.irq_id, $time);
                    check_eq("unexpected_grant", int'(bus.irq_id), 0);
                end else begin
                    $display("grant irq_id=%0d (unchecked) t=%0t", bus.irq_id, $time);
                end
            end
            prev = bus.irq;
        end
    end

    // CPU model: acknowledges after irq has been seen for ack_delay+1 cycles.
    initial begin : responder
        int hi;
        hi = 0;
        forever begin
            @(negedge clk);
            if (ack_en) begin
                if (bus.irq) begin
                    hi++;
                    bus.irq_ack = (hi > ack_delay);
                end else begin
                    hi = 0;
                    bus.irq_ack = 1'b0;
                end
            end else begin
                hi = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int gc0;
        int t;
        int seen;
        bus.mask    = 8'hFF;
        bus.irq_ack = 1'b0;

        // Reset state
        tick(3);
        check_eq("rst_irq", int'(bus.irq), 0);
        check_eq("rst_irq_id", int'(bus.irq_id), 0);
        nreset = 1'b1;
        tick(1);
        check_eq("rst_pending", int'(bus.pending), 0);
        check_eq("rst_held", int'(bus.held), 0);

        // Clean 5-cycle press on left: latency and manual ack
        exp_q.push_back(1);
        left = 1'b1;
        tick(5);
        check_eq("t1_held_pre", int'(bus.held[0]), 0);
        left = 1'b0;
        tick(1);
        check_eq("t1_held_rise", int'(bus.held[0]), 1);
        tick(1);
        check_eq("t1_pending", int'(bus.pending), 8'h01);
        check_eq("t1_irq_pre", int'(bus.irq), 0);
        tick(1);
        check_eq("t1_irq", int'(bus.irq), 1);
        check_eq("t1_irq_id", int'(bus.irq_id), 1);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        check_eq("t1_irq_after_ack", int'(bus.irq), 0);
        check_eq("t1_pending_after_ack", int'(bus.pending), 0);
        wait_drain("t1_drain", 5);
        tick(10);

        // 3-cycle glitch on a: rejected
        a = 1'b1;
        tick(3);
        a = 1'b0;
        seen = 0;
        repeat (12) begin
            tick(1);
            seen = seen | int'(bus.held[6]);
        end
        check_eq("t2_glitch_held", seen, 0);
        check_eq("t2_glitch_pending", int'(bus.pending), 0);
        check_eq("t2_glitch_irq", int'(bus.irq), 0);

        // 4-cycle pulse on a: just long enough
        ack_en = 1'b1;
        ack_delay = 0;
        exp_q.push_back(7);
        a = 1'b1;
        tick(4);
        a = 1'b0;
        wait_drain("t2b_drain", 30);
        tick(10);

        // left + down together: round-robin alternates through repeats
        ack_delay = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(1);
            exp_q.push_back(3);
        end
        left = 1'b1;
        down = 1'b1;
        wait_drain("t3_drain", 100);
        strict = 1'b0;
        left = 1'b0;
        down = 1'b0;
        tick(60);
        strict = 1'b1;
        check_eq("t3_quiet_pending", int'(bus.pending), 0);
        check_eq("t3_quiet_irq", int'(bus.irq), 0);

        // down held 40 cycles, immediate ack: 1 press + 7 repeats
        ack_delay = 0;
        gc0 = grant_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back(3);
        down = 1'b1;
        tick(40);
        down = 1'b0;
        tick(40);
        check_eq("t4_grant_count", grant_cnt - gc0, 8);
        check_eq("t4_sb_left", exp_q.size(), 0);
        exp_q.delete();

        // Masked b: no event, and unmasking while held does not create one
        bus.mask = 8'h7F;
        b = 1'b1;
        tick(15);
        check_eq("t5_held_b", int'(bus.held[7]), 1);
        check_eq("t5_pending_masked", int'(bus.pending[7]), 0);
        check_eq("t5_irq_masked", int'(bus.irq), 0);
        bus.mask = 8'hFF;
        tick(10);
        check_eq("t5_pending_unmasked", int'(bus.pending[7]), 0);
        check_eq("t5_irq_unmasked", int'(bus.irq), 0);
        b = 1'b0;
        tick(10);

        // Mask clears a waiting event but not the in-flight grant
        ack_en = 1'b0;
        exp_q.push_back(4);
        up = 1'b1;
        select = 1'b1;
        tick(10);
        check_eq("t5b_irq_id", int'(bus.irq_id), 4);
        check_eq("t5b_pending_both", int'(bus.pending), 8'h18);
        bus.mask = 8'hEF;
        tick(1);
        check_eq("t5b_pending_cleared", int'(bus.pending), 8'h08);
        check_eq("t5b_irq_inflight", int'(bus.irq), 1);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        check_eq("t5b_pending_acked", int'(bus.pending), 0);
        up = 1'b0;
        select = 1'b0;
        tick(15);
        bus.mask = 8'hFF;
        tick(5);
        check_eq("t5b_irq_quiet", int'(bus.irq), 0);
        wait_drain("t5b_drain", 5);

        // Reset during GRANT drops everything without a clock edge
        exp_q.push_back(2);
        right = 1'b1;
        t = 0;
        while (!bus.irq && t < 20) begin
            tick(1);
            t++;
        end
        check_eq("t6_irq_before_rst", int'(bus.irq), 1);
        right = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        check_eq("t6_rst_irq", int'(bus.irq), 0);
        check_eq("t6_rst_irq_id", int'(bus.irq_id), 0);
        check_eq("t6_rst_pending", int'(bus.pending), 0);
        check_eq("t6_rst_held", int'(bus.held), 0);
        tick(2);
        nreset = 1'b1;
        exp_q.delete();
        tick(1);

        // After reset, left wins over down
        ack_en = 1'b1;
        ack_delay = 0;
        exp_q.push_back(1);
        exp_q.push_back(3);
        left = 1'b1;
        down = 1'b1;
        tick(6);
        left = 1'b0;
        down = 1'b0;
        wait_drain("t6_drain", 40);
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
